// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_fetch_if #(
    parameter int unsigned XLEN = 64
);
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_resp_valid_i;
    logic [63:0]     imem_resp_data_i;
    logic            imem_resp_err_i;

    modport master (
        output imem_req_valid_o,
        output imem_req_addr_o,
        input  imem_req_ready_i,
        input  imem_resp_valid_i,
        input  imem_resp_data_i,
        input  imem_resp_err_i
    );

    modport slave (
        input  imem_req_valid_o,
        input  imem_req_addr_o,
        output imem_req_ready_i,
        output imem_resp_valid_i,
        output imem_resp_data_i,
        output imem_resp_err_i
    );
endinterface

// File: rtl/if_fetch.sv
// Single-outstanding instruction fetch stage: one doubleword read per PC, 32-bit slot select.
// Optional macro IF_MISALIGN_TRAP_EN: misaligned PCs fault in IDLE without a memory request.
module if_fetch #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            if_ram_valid_i,
    input  logic            stall_valid_i,
    input  logic            flush_valid_i,
    if_fetch_if.master      imem,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_fault_o,
    output logic            fetch_busy_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     inst_q, inst_d;
    logic            fault_q, fault_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    logic            busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            drop_q       <= 1'b0;
            pc_q         <= RESET_PC;
            addr_q       <= '0;
            inst_q       <= NOP;
            fault_q      <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            inst_q       <= inst_d;
            fault_q      <= fault_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Next state; status outputs are registered copies of the decoded next state.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                if (if_ram_valid_i && !flush_valid_i) begin
                    pc_d    = pc_i;
                    addr_d  = {pc_i[XLEN-1:3], 3'b000};
                    drop_d  = 1'b0;
                    state_d = S_REQ;
`ifdef IF_MISALIGN_TRAP_EN
                    if (pc_i[1:0] != 2'b00) begin
                        addr_d  = addr_q;
                        inst_d  = NOP;
                        fault_d = 1'b1;
                        state_d = S_OUT;
                    end
`else
`endif
                end
            end
            S_REQ: begin
                // A flush never withdraws the request; it only marks the reply for discard.
                if (imem.imem_req_ready_i) begin
                    state_d = (flush_valid_i || drop_q) ? S_DRAIN : S_WAIT;
                    drop_d  = 1'b0;
                end else if (flush_valid_i) begin
                    drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem.imem_resp_valid_i) begin
                    if (flush_valid_i) begin
                        state_d = S_IDLE;
                    end else begin
                        inst_d  = pc_q[2] ? imem.imem_resp_data_i[63:32]
                                          : imem.imem_resp_data_i[31:0];
                        fault_d = imem.imem_resp_err_i;
                        state_d = S_OUT;
                    end
                end else if (flush_valid_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem.imem_resp_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                if (flush_valid_i || !stall_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_valid_d  = (state_d == S_REQ);
        inst_valid_d = (state_d == S_OUT);
        busy_d       = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_DRAIN);
    end

    assign imem.imem_req_valid_o = req_valid_q;
    assign imem.imem_req_addr_o  = addr_q;
    assign inst_valid_o          = inst_valid_q;
    assign inst_o                = inst_q;
    assign inst_pc_o             = pc_q;
    assign inst_fault_o          = fault_q;
    assign fetch_busy_o          = busy_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch: latency, backpressure, flush, stall, fault and reset.
module tb_if_fetch;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc_i;
    logic            if_ram_valid_i;
    logic            stall_valid_i;
    logic            flush_valid_i;
    logic            inst_valid_o;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            inst_fault_o;
    logic            fetch_busy_o;

    int checks = 0;
    int errors = 0;

    if_fetch_if #(.XLEN(XLEN)) bus ();

    if_fetch #(.XLEN(XLEN), .RESET_PC(64'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .if_ram_valid_i (if_ram_valid_i),
        .stall_valid_i  (stall_valid_i),
        .flush_valid_i  (flush_valid_i),
        .imem           (bus),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_fault_o   (inst_fault_o),
        .fetch_busy_o   (fetch_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_valid"}, 64'(bus.imem_req_valid_o), 64'd0);
        chk({tag, "_req_addr"},  64'(bus.imem_req_addr_o),  64'd0);
        chk({tag, "_inst_valid"}, 64'(inst_valid_o), 64'd0);
        chk({tag, "_inst"},      64'(inst_o),        64'h13);
        chk({tag, "_inst_pc"},   64'(inst_pc_o),     64'h8000_0000);
        chk({tag, "_fault"},     64'(inst_fault_o),  64'd0);
        chk({tag, "_busy"},      64'(fetch_busy_o),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst                  = 1'b1;
        pc_i                 = '0;
        if_ram_valid_i       = 1'b0;
        stall_valid_i        = 1'b0;
        flush_valid_i        = 1'b0;
        bus.imem_req_ready_i  = 1'b0;
        bus.imem_resp_valid_i = 1'b0;
        bus.imem_resp_data_i  = '0;
        bus.imem_resp_err_i   = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

        // Minimum-latency fetch of the upper word
        pc_i = 64'h8000_0004; if_ram_valid_i = 1'b1; bus.imem_req_ready_i = 1'b1;
        tick();
        if_ram_valid_i = 1'b0;
        chk("lat_req_valid", 64'(bus.imem_req_valid_o), 64'd1);
        chk("lat_addr",      64'(bus.imem_req_addr_o),  64'h8000_0000);
        chk("lat_busy_req",  64'(fetch_busy_o),         64'd1);
        chk("lat_pc",        64'(inst_pc_o),            64'h8000_0004);
        chk("lat_iv_req",    64'(inst_valid_o),         64'd0);
        tick();
        chk("lat_req_drop",  64'(bus.imem_req_valid_o), 64'd0);
        chk("lat_busy_wait", 64'(fetch_busy_o),         64'd1);
        chk("lat_iv_wait",   64'(inst_valid_o),         64'd0);
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_data_i = 64'h1111_2222_3333_4444;
        tick();
        bus.imem_resp_valid_i = 1'b0;
        chk("lat_iv_out",    64'(inst_valid_o), 64'd1);
        chk("lat_inst",      64'(inst_o),       64'h1111_2222);
        chk("lat_fault",     64'(inst_fault_o), 64'd0);
        chk("lat_busy_out",  64'(fetch_busy_o), 64'd0);
        tick();
        chk("lat_iv_idle",   64'(inst_valid_o), 64'd0);
        chk("lat_inst_hold", 64'(inst_o),       64'h1111_2222);

        // Stray response in IDLE is ignored
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus.imem_resp_valid_i = 1'b0;
        chk("stray_iv",   64'(inst_valid_o), 64'd0);
        chk("stray_busy", 64'(fetch_busy_o), 64'd0);
        chk("stray_inst", 64'(inst_o),       64'h1111_2222);

        // Backpressure: ready low for 4 cycles
        bus.imem_req_ready_i = 1'b0;
        pc_i = 64'h8000_1010; if_ram_valid_i = 1'b1;
        tick();
        if_ram_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_valid", 64'(bus.imem_req_valid_o), 64'd1);
            chk("bp_addr",      64'(bus.imem_req_addr_o),  64'h8000_1010);
            chk("bp_busy",      64'(fetch_busy_o),         64'd1);
            tick();
        end
        bus.imem_req_ready_i = 1'b1;
        tick();
        chk("bp_busy_wait", 64'(fetch_busy_o),         64'd1);
        chk("bp_req_drop",  64'(bus.imem_req_valid_o), 64'd0);
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_data_i = 64'hAAAA_BBBB_CCCC_DDDD;
        stall_valid_i = 1'b1;
        tick();
        bus.imem_resp_valid_i = 1'b0;
        chk("bp_iv",   64'(inst_valid_o), 64'd1);
        chk("bp_inst", 64'(inst_o),       64'hCCCC_DDDD);
        chk("bp_busy", 64'(fetch_busy_o), 64'd0);

        // Stall in OUT for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_iv",   64'(inst_valid_o), 64'd1);
            chk("stall_inst", 64'(inst_o),       64'hCCCC_DDDD);
            chk("stall_pc",   64'(inst_pc_o),    64'h8000_1010);
        end
        stall_valid_i = 1'b0;
        tick();
        chk("stall_release_iv", 64'(inst_valid_o), 64'd0);

        // Flush in WAIT, response two cycles later
        pc_i = 64'h8000_2008; if_ram_valid_i = 1'b1;
        tick();
        if_ram_valid_i = 1'b0;
        tick();
        flush_valid_i = 1'b1;
        tick();
        flush_valid_i = 1'b0;
        chk("drain_busy", 64'(fetch_busy_o), 64'd1);
        chk("drain_iv",   64'(inst_valid_o), 64'd0);
        tick();
        chk("drain_busy2", 64'(fetch_busy_o), 64'd1);
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_data_i = 64'h9999_8888_7777_6666;
        tick();
        bus.imem_resp_valid_i = 1'b0;
        chk("drain_done_busy", 64'(fetch_busy_o), 64'd0);
        chk("drain_done_iv",   64'(inst_valid_o), 64'd0);
        chk("drain_inst_keep", 64'(inst_o),       64'hCCCC_DDDD);
        chk("drain_pc",        64'(inst_pc_o),    64'h8000_2008);
        pc_i = 64'h8000_300C; if_ram_valid_i = 1'b1;
        tick();
        if_ram_valid_i = 1'b0;
        chk("post_drain_req",  64'(bus.imem_req_valid_o), 64'd1);
        chk("post_drain_addr", 64'(bus.imem_req_addr_o),  64'h8000_3008);
        tick();
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_data_i = 64'h5555_6666_7777_8888;
        tick();
        bus.imem_resp_valid_i = 1'b0;
        chk("post_drain_iv",   64'(inst_valid_o), 64'd1);
        chk("post_drain_inst", 64'(inst_o),       64'h5555_6666);
        tick();

        // Flush while request is stalled: request held, reply discarded
        bus.imem_req_ready_i = 1'b0;
        pc_i = 64'h8000_4000; if_ram_valid_i = 1'b1;
        tick();
        if_ram_valid_i = 1'b0; flush_valid_i = 1'b1;
        tick();
        flush_valid_i = 1'b0;
        chk("reqflush_valid", 64'(bus.imem_req_valid_o), 64'd1);
        chk("reqflush_addr",  64'(bus.imem_req_addr_o),  64'h8000_4000);
        bus.imem_req_ready_i = 1'b1;
        tick();
        chk("reqflush_busy",  64'(fetch_busy_o),         64'd1);
        chk("reqflush_drop",  64'(bus.imem_req_valid_o), 64'd0);
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_data_i = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.imem_resp_valid_i = 1'b0;
        chk("reqflush_idle", 64'(fetch_busy_o), 64'd0);
        chk("reqflush_iv",   64'(inst_valid_o), 64'd0);
        chk("reqflush_inst", 64'(inst_o),       64'h5555_6666);

        // Access fault response
        pc_i = 64'h8000_0000; if_ram_valid_i = 1'b1;
        tick();
        if_ram_valid_i = 1'b0;
        tick();
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_err_i = 1'b1;
        bus.imem_resp_data_i = 64'hFFFF_EEEE_DDDD_CCCC;
        tick();
        bus.imem_resp_valid_i = 1'b0; bus.imem_resp_err_i = 1'b0;
        chk("err_iv",    64'(inst_valid_o), 64'd1);
        chk("err_fault", 64'(inst_fault_o), 64'd1);
        chk("err_inst",  64'(inst_o),       64'hDDDD_CCCC);
        tick();

        // Asynchronous reset in WAIT, late response ignored
        pc_i = 64'h8000_0008; if_ram_valid_i = 1'b1;
        tick();
        if_ram_valid_i = 1'b0;
        tick();
        chk("rst_pre_busy", 64'(fetch_busy_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        tick();
        rst = 1'b0;
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_data_i = 64'h7777_7777_7777_7777;
        tick();
        bus.imem_resp_valid_i = 1'b0;
        chk("late_iv",   64'(inst_valid_o), 64'd0);
        chk("late_busy", 64'(fetch_busy_o), 64'd0);
        chk("late_inst", 64'(inst_o),       64'h13);
        tick();

        // Misaligned PC
        pc_i = 64'h8000_0002; if_ram_valid_i = 1'b1;
        tick();
        if_ram_valid_i = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis_req",   64'(bus.imem_req_valid_o), 64'd0);
        chk("mis_iv",    64'(inst_valid_o),         64'd1);
        chk("mis_fault", 64'(inst_fault_o),         64'd1);
        chk("mis_inst",  64'(inst_o),               64'h13);
        chk("mis_pc",    64'(inst_pc_o),            64'h8000_0002);
        tick();
`else
        chk("mis_req",  64'(bus.imem_req_valid_o), 64'd1);
        chk("mis_addr", 64'(bus.imem_req_addr_o),  64'h8000_0000);
        chk("mis_pc",   64'(inst_pc_o),            64'h8000_0002);
        tick();
        bus.imem_resp_valid_i = 1'b1; bus.imem_resp_data_i = 64'h2222_3333_4444_5555;
        tick();
        bus.imem_resp_valid_i = 1'b0;
        chk("mis_iv",    64'(inst_valid_o), 64'd1);
        chk("mis_inst",  64'(inst_o),       64'h4444_5555);
        chk("mis_fault", 64'(inst_fault_o), 64'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter XLEN, default 64, width of PC and memory bus.
REQ-002 Parameter RESET_PC, default 64'h8000_0000, value of inst_pc_o after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_i  input  XLEN  fetch address from the PC register.
REQ-006 if_ram_valid_i  input  1  PC register permits a fetch of pc_i this cycle.
REQ-007 stall_valid_i  input  1  downstream stall; decode does not consume inst this cycle.
REQ-008 flush_valid_i  input  1  pipeline flush; discard current and in-flight fetch.
REQ-009 imem_req_valid_o  output  1  read request valid.
REQ-010 imem_req_ready_i  input  1  memory accepts request.
REQ-011 imem_req_addr_o  output  XLEN  request address, 8-byte aligned.
REQ-012 imem_resp_valid_i  input  1  read data valid, one cycle per accepted request.
REQ-013 imem_resp_data_i  input  64  read data doubleword.
REQ-014 imem_resp_err_i  input  1  access fault, qualified by imem_resp_valid_i.
REQ-015 inst_valid_o  output  1  instruction presented to decode.
REQ-016 inst_o  output  32  fetched instruction.
REQ-017 inst_pc_o  output  XLEN  PC of inst_o.
REQ-018 inst_fault_o  output  1  access fault for inst_pc_o, qualified by inst_valid_o.
REQ-019 fetch_busy_o  output  1  fetch in progress; pipeline stalls the PC register.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, OUT, DRAIN; one-hot or binary free.
REQ-021 IDLE: if_ram_valid_i & ~flush_valid_i -> capture pc_i into pc_q, go REQ; else stay.
REQ-022 REQ: imem_req_valid_o=1, addr={pc_q[XLEN-1:3],3'b0}; on imem_req_ready_i -> WAIT (or DRAIN if flush_valid_i same cycle).
REQ-023 Once imem_req_valid_o asserts it SHALL hold with stable address until ready; flush never withdraws it.
REQ-024 REQ with flush_valid_i and no ready -> remain REQ, set drop flag; on accept go DRAIN.
REQ-025 WAIT: on imem_resp_valid_i capture inst = pc_q[2] ? data[63:32] : data[31:0], capture err, go OUT; flush (no resp) -> DRAIN; flush with resp same cycle -> IDLE, data discarded.
REQ-026 DRAIN: on imem_resp_valid_i discard, go IDLE; inst_valid_o stays 0.
REQ-027 OUT: inst_valid_o=1; ~stall_valid_i -> consumed, go IDLE; stall -> hold outputs stable; flush -> IDLE, inst_valid_o=0 next cycle.
REQ-028 Minimum latency: pc accepted in IDLE cycle N, ready in N+1, resp in N+2 -> inst_valid_o at N+3.
REQ-029 fetch_busy_o = state in {REQ, WAIT, DRAIN}.
REQ-030 inst_o, inst_pc_o, inst_fault_o SHALL change only on IDLE->REQ (pc) or resp capture (inst, fault).
REQ-031 imem_resp_valid_i in IDLE/REQ/OUT is a protocol error; SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE immediately, mid-transaction included; outstanding response after reset ignored.
REQ-033 Reset values: imem_req_valid_o=0, imem_req_addr_o=0, inst_valid_o=0, inst_o=32'h0000_0013, inst_pc_o=RESET_PC, inst_fault_o=0, fetch_busy_o=0.

Configuration
REQ-034 Macro IF_MISALIGN_TRAP_EN defined: IDLE launch with pc_i[1:0]!=0 SHALL skip memory, go OUT with inst_o=32'h0000_0013, inst_fault_o=1, inst_pc_o=pc_i.
REQ-035 Macro undefined: pc_i[1:0] ignored, fetch proceeds normally, no misalign detection logic.

Verification
REQ-036 pc_i=0x8000_0004, ready immediate, resp data 0x1111_2222_3333_4444 -> inst_o=0x1111_2222, inst_valid_o 3 cycles after launch, addr 0x8000_0000.
REQ-037 ready held low 4 cycles -> req_valid and addr stable throughout; busy=1 until resp.
REQ-038 flush in WAIT, resp 2 cycles later -> DRAIN, no inst_valid_o, next IDLE accepts new pc.
REQ-039 OUT with stall_valid_i high 3 cycles -> outputs stable; stall drops -> IDLE next cycle.
REQ-040 resp with err=1 at pc 0x8000_0000 -> inst_valid_o=1, inst_fault_o=1; rst pulsed in WAIT -> all outputs at reset values, late resp ignored.
REQ-041 IF_MISALIGN_TRAP_EN defined, pc_i=0x8000_0002 -> no request issued, inst_fault_o=1 next cycle.
